wdt_ctrl: RTL
=============

WDT_CTRL -- requirements
Module: wdt_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter and configuration width.
REQ-002 SHALL have parameter KICK_KEY, default 32'h5A5A_A5A5, the only key value that makes a kick valid.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-006 SHALL have ports cfg_timeout, cfg_warn and cfg_window  input  WIDTH  bite count, warning count and earliest legal kick count.
REQ-007 SHALL have port enable  input  1  arms the watchdog.
REQ-008 SHALL have ports kick  input  1  and kick_key  input  WIDTH  service request and its key.
REQ-009 SHALL have port irq  output  1  early-warning interrupt, level.
REQ-010 SHALL have port bite  output  1  system reset request, sticky level.
REQ-011 SHALL have ports locked  output  1  (configuration frozen), state  output  2  (current FSM state) and count  output  WIDTH  (current count).

Function
REQ-012 SHALL implement FSM states IDLE=0, RUN=1, WARN=2, BITE=3, encoded on the state output.
REQ-013 SHALL latch cfg_timeout, cfg_warn and cfg_window on a cycle where cfg_we=1, state=IDLE and locked=0; SHALL ignore cfg_we in every other case.
REQ-014 SHALL move IDLE->RUN on the edge where enable=1, clearing count to 0 and setting locked=1.
REQ-015 If cfg_we and enable are both 1 in IDLE, SHALL latch the new configuration and arm with it on the same edge.
REQ-016 Once locked=1, SHALL ignore enable deasserting; locked clears only on reset.
REQ-017 In RUN and WARN, SHALL increment count by 1 per cycle.
REQ-018 On the edge where count==cfg_warn in RUN, SHALL move RUN->WARN and set irq=1.
REQ-019 A valid kick is kick=1, kick_key==KICK_KEY and count>=cfg_window.
REQ-020 On a valid kick in RUN or WARN, SHALL clear count to 0, clear irq and enter RUN on the next edge.
REQ-021 In RUN or WARN, kick=1 with a wrong key or with count<cfg_window SHALL enter BITE on the next edge.
REQ-022 On the edge where count==cfg_timeout in RUN or WARN with no valid kick, SHALL enter BITE.
REQ-023 On a cycle where a valid kick and count==cfg_timeout coincide, the kick SHALL win.
REQ-024 On a cycle where count==cfg_warn and count==cfg_timeout coincide, SHALL enter BITE and not WARN.
REQ-025 If cfg_warn>cfg_timeout, WARN SHALL never be entered.
REQ-026 cfg_window=0 SHALL disable the window check.
REQ-027 In BITE, SHALL hold bite=1, keep irq at its last value and freeze count.
REQ-028 In BITE, SHALL ignore all inputs except reset.
REQ-029 SHALL not wrap count: with cfg_timeout=2^WIDTH-1, BITE is entered at the all-ones value.
REQ-030 In IDLE, SHALL ignore kick.
REQ-031 All outputs SHALL be registered; bite, irq and state change one edge after the triggering condition.

Reset
REQ-032 On reset=1 at a rising edge, SHALL set state=IDLE, count=0, irq=0, bite=0 and locked=0.
REQ-033 On reset, SHALL set cfg_timeout=all-ones, cfg_warn=all-ones and cfg_window=0.
REQ-034 Reset SHALL take priority over every other input, including mid-RUN and in BITE.

Structure
REQ-035 Package wdt_pkg SHALL hold the state enumeration and the default KICK_KEY constant.
REQ-036 Sub-module wdt_counter SHALL hold the WIDTH-bit counter with clear, increment and hold controls.
REQ-037 wdt_ctrl SHALL hold only the FSM, the configuration registers and the compare logic.

Verification
REQ-038 Configure timeout=20, warn=15, window=0, enable, no kicks -> irq rises 16 cycles after arming, bite rises 21 cycles after arming, count frozen at 20.
REQ-039 timeout=20, warn=15, window=5, valid kick at count=10 -> count returns to 0, state RUN, irq stays 0, no bite.
REQ-040 window=5, valid-key kick at count=3 -> bite the next cycle; kick at count=8 with key 32'h0 -> bite the next cycle.
REQ-041 Valid kick at count==20==timeout -> no bite, count=0; separately, kick while in WARN -> irq clears and state returns to RUN.
REQ-042 After arming, cfg_we with new values and enable=0 -> configuration unchanged, locked stays 1; assert reset in BITE -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: FSM state encoding (visible on the state output)
// and the default kick key.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_BITE = 2'd3
    } wdt_state_e;

    localparam logic [31:0] WDT_KICK_KEY = 32'h5A5A_A5A5;

endpackage

// File: rtl/wdt_ctrl_if.sv
// Watchdog control bus: configuration, arming and kick requests in; status out.
interface wdt_ctrl_if #(
    parameter int unsigned WIDTH = 32
);

    logic             cfg_we;
    logic [WIDTH-1:0] cfg_timeout;
    logic [WIDTH-1:0] cfg_warn;
    logic [WIDTH-1:0] cfg_window;
    logic             enable;
    logic             kick;
    logic [WIDTH-1:0] kick_key;
    logic             irq;
    logic             bite;
    logic             locked;
    logic [1:0]       state;
    logic [WIDTH-1:0] count;

    modport master (
        output cfg_we, cfg_timeout, cfg_warn, cfg_window, enable, kick, kick_key,
        input  irq, bite, locked, state, count
    );

    modport slave (
        input  cfg_we, cfg_timeout, cfg_warn, cfg_window, enable, kick, kick_key,
        output irq, bite, locked, state, count
    );

endinterface

// File: rtl/wdt_counter.sv
// Watchdog tick counter: clear has priority over increment; otherwise holds.
module wdt_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/wdt_ctrl.sv
// Windowed watchdog: FSM, configuration registers and compare logic.
// Configuration is frozen once armed; only reset leaves BITE.
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] KICK_KEY = WIDTH'(WDT_KICK_KEY)
) (
    input  logic      clk,
    input  logic      reset,
    wdt_ctrl_if.slave bus
);

    wdt_state_e       state_q, state_d;
    logic             irq_q, irq_d;
    logic             bite_q, bite_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] timeout_q, timeout_d;
    logic [WIDTH-1:0] warn_q, warn_d;
    logic [WIDTH-1:0] window_q, window_d;
    logic [WIDTH-1:0] count;
    logic             cnt_clr, cnt_inc;
    logic             kick_ok, at_timeout, at_warn;

    wdt_counter #(.WIDTH(WIDTH)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (count)
    );

    assign kick_ok    = bus.kick && (bus.kick_key == KICK_KEY) && (count >= window_q);
    assign at_timeout = (count == timeout_q);
    assign at_warn    = (count == warn_q);

    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        bite_d    = bite_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        warn_d    = warn_q;
        window_d  = window_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_we && !locked_q) begin
                    timeout_d = bus.cfg_timeout;
                    warn_d    = bus.cfg_warn;
                    window_d  = bus.cfg_window;
                end
                if (bus.enable) begin
                    state_d  = ST_RUN;
                    locked_d = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            ST_RUN, ST_WARN: begin
                // Valid kick beats timeout; timeout beats the warning threshold.
                if (kick_ok) begin
                    state_d = ST_RUN;
                    irq_d   = 1'b0;
                    cnt_clr = 1'b1;
                end else if (bus.kick || at_timeout) begin
                    state_d = ST_BITE;
                    bite_d  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (state_q == ST_RUN && at_warn) begin
                        state_d = ST_WARN;
                        irq_d   = 1'b1;
                    end
                end
            end
            ST_BITE: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            bite_q    <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= '1;
            warn_q    <= '1;
            window_q  <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            bite_q    <= bite_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            warn_q    <= warn_d;
            window_q  <= window_d;
        end
    end

    assign bus.irq    = irq_q;
    assign bus.bite   = bite_q;
    assign bus.locked = locked_q;
    assign bus.state  = state_q;
    assign bus.count  = count;

endmodule
